// File: rtl/lcd_pixel_prefetch.sv
// Frame-aligned pixel prefetch FIFO feeding the LCD timing driver.
// Each early request from the driver is answered with a registered pixel on the next edge.
module lcd_pixel_prefetch #(
    parameter int               DATA_W     = 16,
    parameter int               DEPTH      = 64,
    parameter int               AW         = 6,
    parameter int               FILL_LEVEL = 32,
    parameter int               H_DISP     = 480,
    parameter int               V_DISP     = 272,
    parameter int               PCNT_W     = 17,
    parameter logic [DATA_W-1:0] BG_COLOR  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    input  logic              src_sof,
    output logic              src_ready,
    input  logic              lcd_request,
    input  logic              lcd_framesync,
    output logic [DATA_W-1:0] lcd_data,
    output logic [AW:0]       fifo_level,
    output logic              underflow,
    output logic              frame_err
);

    localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]       FILL_L  = (AW+1)'(FILL_LEVEL);
    localparam logic [PCNT_W-1:0] FRAME_L = PCNT_W'(H_DISP * V_DISP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FILL  = 2'd2,
        RUN   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         level_q, level_d;
    logic [PCNT_W-1:0]   count_q, count_d;
    logic                underflow_q, underflow_d;
    logic                frame_err_q, frame_err_d;
    logic                fs_q;
    logic [DATA_W-1:0]   lcd_data_q;

    logic                fse;
    logic                accept;
    logic                counted;
    logic                pop;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;

    assign fse       = fs_q & ~lcd_framesync;
    assign src_ready = (state_q != IDLE) && (level_q < DEPTH_L);
    assign accept    = src_valid & src_ready;
    assign counted   = lcd_request && (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        frame_err_d = 1'b0;
        pop         = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;

        if (fse) begin
            // Frame start always wins: drop everything and wait for the next SOF.
            frame_err_d = (state_q != IDLE);
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            count_d     = '0;
            underflow_d = 1'b0;
            state_d     = FLUSH;
        end else if (accept && src_sof && (state_q == FILL || state_q == RUN)) begin
            // Stray SOF: restart the frame with this word as the only entry.
            frame_err_d = 1'b1;
            mem_we      = 1'b1;
            mem_waddr   = '0;
            wr_ptr_d    = AW'(1);
            rd_ptr_d    = '0;
            level_d     = (AW+1)'(1);
            count_d     = '0;
            underflow_d = underflow_q | counted;
            state_d     = FILL;
        end else begin
            mem_we   = accept && (state_q != FLUSH || src_sof);
            pop      = lcd_request && (state_q == RUN) && (level_q != '0);
            wr_ptr_d = wr_ptr_q + AW'(mem_we);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + (AW+1)'(mem_we) - (AW+1)'(pop);
            if (counted) begin
                count_d = count_q + PCNT_W'(1);
            end
            if (counted && !pop) begin
                underflow_d = 1'b1;
            end
            case (state_q)
                FLUSH: if (mem_we) state_d = FILL;
                FILL:  if (level_d >= FILL_L || lcd_request) state_d = RUN;
                RUN:   if (counted && count_d == FRAME_L) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            frame_err_q <= 1'b0;
            fs_q        <= 1'b1;
            lcd_data_q  <= BG_COLOR;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            frame_err_q <= frame_err_d;
            fs_q        <= lcd_framesync;
            lcd_data_q  <= pop ? mem[rd_ptr_q] : BG_COLOR;
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= src_data;
        end
    end

    assign lcd_data   = lcd_data_q;
    assign fifo_level = level_q;
    assign underflow  = underflow_q;
    assign frame_err  = frame_err_q;

endmodule
